// File: rtl/ysyx_24100005_pkg.sv
// Shared definitions for the ysyx_24100005 instruction fetch path:
// SYSTEM-opcode constants and the IFU state type.
package ysyx_24100005_pkg;

   localparam logic [6:0]  OPC_SYSTEM  = 7'b1110011;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   typedef enum logic {
      FETCH = 1'b0,
      HALT  = 1'b1
   } ifu_state_e;

   // Exact match only, so ecall (same opcode, imm=0) is never mistaken for ebreak.
   function automatic logic is_ebreak(input logic [31:0] word);
      return (word[6:0] == OPC_SYSTEM) && (word == INST_EBREAK);
   endfunction

endpackage

// File: rtl/ysyx_24100005_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head, occupancy count and flush.
// Push while full is accepted only when a pop frees the slot in the same cycle.
module ysyx_24100005_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int SLOTS = 1 << AW;

   logic [WIDTH-1:0] mem [SLOTS];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] bump(input logic [AW-1:0] ptr);
      return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= bump(wr_ptr);
         if (do_pop)  rd_ptr <= bump(rd_ptr);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
      end
   end

   // Storage is not reset; only slots between the pointers are ever treated as valid.
   always_ff @(posedge clk) begin
      if (!rst && !flush && do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: owns the PC, issues credit-limited in-order fetches,
// buffers returned instructions for decode, handles redirects and ebreak halt.
module ysyx_24100005_ifu
   import ysyx_24100005_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = XLEN'(32'h8000_0000),
   parameter int              DEPTH       = 2,
   parameter bit              EBREAK_HALT = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   output logic            req_valid,
   input  logic            req_ready,
   output logic [XLEN-1:0] req_addr,
   input  logic            resp_valid,
   input  logic [31:0]     resp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] inst_pc,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            ebreak_o,
   output logic            halted
);

   localparam int          CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

   ifu_state_e       state;
   logic [XLEN-1:0]  pc_q;
   logic [CW-1:0]    discard;
   logic [CW-1:0]    outstanding;
   logic [CW-1:0]    outstanding_next;
   logic [CW-1:0]    inst_count;
   logic [CW:0]      credit_used;
   logic [XLEN-1:0]  tag_head;
   logic [XLEN+31:0] inst_head;
   logic             tag_empty;
   logic             tag_full;
   logic             inst_empty;
   logic             inst_full;
   logic             req_fire;
   logic             inst_fire;
   logic             redirect_take;
   logic             ebreak_take;
   logic             drop_discard;
   logic             inst_push;
   logic             inst_flush;
   logic [1:0]       unused_redirect_low;

   // Every fetch holds one credit from acceptance until decode consumes or the IFU drops it.
   assign credit_used = {1'b0, outstanding} + {1'b0, inst_count};
   assign req_valid   = !rst && (state == FETCH) && (credit_used < DEPTH_W);
   assign req_addr    = pc_q;
   assign inst_valid  = (state == FETCH) && !inst_empty;
   assign inst        = inst_head[XLEN+31:XLEN];
   assign inst_pc     = inst_head[XLEN-1:0];
   assign halted      = (state == HALT);

   assign req_fire      = req_valid && req_ready;
   assign inst_fire     = inst_valid && inst_ready;
   assign redirect_take = redirect_valid && (state == FETCH);
   assign ebreak_take   = inst_fire && is_ebreak(inst);
   assign drop_discard  = resp_valid && (discard != '0);
   assign inst_push     = resp_valid && (discard == '0) && (state == FETCH);
   assign inst_flush    = redirect_take || (ebreak_take && EBREAK_HALT);

   assign outstanding_next    = outstanding + CW'(req_fire) - CW'(resp_valid);
   assign unused_redirect_low = redirect_pc[1:0];

   // The tag FIFO is never flushed, so its occupancy is exactly the in-flight count.
   ysyx_24100005_sync_fifo #(
      .WIDTH (XLEN),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (1'b0),
      .push      (req_fire),
      .push_data (pc_q),
      .pop       (resp_valid),
      .head      (tag_head),
      .empty     (tag_empty),
      .full      (tag_full),
      .count     (outstanding)
   );

   ysyx_24100005_sync_fifo #(
      .WIDTH (XLEN + 32),
      .DEPTH (DEPTH)
   ) u_inst_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (inst_flush),
      .push      (inst_push),
      .push_data ({resp_data, tag_head}),
      .pop       (inst_fire),
      .head      (inst_head),
      .empty     (inst_empty),
      .full      (inst_full),
      .count     (inst_count)
   );

   // On redirect every response still owed after this cycle belongs to the old path.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FETCH;
         pc_q     <= RESET_PC;
         discard  <= '0;
         ebreak_o <= 1'b0;
      end else begin
         ebreak_o <= ebreak_take;
         if (redirect_take) begin
            pc_q    <= {redirect_pc[XLEN-1:2], 2'b00};
            discard <= outstanding_next;
         end else begin
            if (req_fire)     pc_q    <= pc_q + XLEN'(4);
            if (drop_discard) discard <= discard - CW'(1);
         end
         if (ebreak_take && EBREAK_HALT) state <= HALT;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(inst_push && !inst_flush && inst_full && !inst_fire));
         assert (!(req_fire && tag_full));
         assert (!(resp_valid && tag_empty));
      end
   end

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Randomised self-checking bench for ysyx_24100005_ifu: a latency-randomised memory
// and a program-order model of what decode must see and which addresses must be fetched.
module tb_ysyx_24100005_ifu;
   import ysyx_24100005_pkg::*;

   localparam int          DEPTH      = 2;
   localparam logic [31:0] RESET_PC   = 32'h8000_0000;
   localparam logic [31:0] WRAP_PC    = 32'hFFFF_FFFC;
   localparam logic [31:0] INST_ECALL = 32'h0000_0073;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        inst_valid, inst_ready;
   logic [31:0] inst, inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        ebreak_o, halted;

   logic        b_rst, b_req_valid, b_req_ready, b_resp_valid, b_inst_valid, b_inst_ready;
   logic        b_redirect_valid, b_ebreak_o, b_halted;
   logic [31:0] b_req_addr, b_resp_data, b_inst, b_inst_pc, b_redirect_pc;

   ysyx_24100005_ifu #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH), .EBREAK_HALT(1'b1)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .resp_valid(resp_valid), .resp_data(resp_data), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .ebreak_o(ebreak_o), .halted(halted)
   );

   ysyx_24100005_ifu #(.XLEN(32), .RESET_PC(WRAP_PC), .DEPTH(DEPTH), .EBREAK_HALT(1'b1)) dut_wrap (
      .clk(clk), .rst(b_rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
      .resp_valid(b_resp_valid), .resp_data(b_resp_data), .inst_valid(b_inst_valid),
      .inst_ready(b_inst_ready), .inst(b_inst), .inst_pc(b_inst_pc), .redirect_valid(b_redirect_valid),
      .redirect_pc(b_redirect_pc), .ebreak_o(b_ebreak_o), .halted(b_halted)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cycle = 0;
   int delivered = 0;
   int last_deliver = 0;
   int req_count = 0;
   int ready_pct, inst_pct, lat_min, lat_max, d0;
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   logic [31:0] exp_pc, exp_fetch;
   logic [31:0] ebreak_addr, ecall_addr;
   logic        halt_model;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == ebreak_addr) return INST_EBREAK;
      if (a == ecall_addr)  return INST_ECALL;
      return {a[24:0] ^ 25'h0AB_CDE, 7'b0010011};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      tests++;
      assert (observed === expected) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic doReset();
      rst = 1'b1; req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
      inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      @(posedge clk); @(posedge clk); #1;
      pend_addr.delete(); pend_due.delete();
      exp_pc = RESET_PC; exp_fetch = RESET_PC; halt_model = 1'b0; req_count = 0;
      last_deliver = cycle;
      checkOutput("rst_req_valid", req_valid, 0);
      checkOutput("rst_inst_valid", inst_valid, 0);
      checkOutput("rst_halted", halted, 0);
      checkOutput("rst_ebreak", ebreak_o, 0);
      rst = 1'b0; #1;
      checkOutput("post_rst_req_valid", req_valid, 1);
      checkOutput("post_rst_req_addr", req_addr, RESET_PC);
   endtask

   // One clock of traffic: decode stream and fetch addresses are checked against program order.
   task automatic applyStimulus(input logic redir, input logic [31:0] target);
      logic        rf, ifire, hit_ebreak, hit_ecall;
      logic [31:0] word, rf_addr;
      hit_ebreak = 1'b0; hit_ecall = 1'b0;
      req_ready      = (int'($urandom_range(99)) < ready_pct);
      inst_ready     = (int'($urandom_range(99)) < inst_pct);
      redirect_valid = redir;
      redirect_pc    = target;
      resp_valid = 1'b0; resp_data = '0;
      if (pend_addr.size() > 0 && pend_due[0] <= cycle) begin
         resp_valid = 1'b1;
         resp_data  = mem_word(pend_addr[0]);
      end
      #1;
      rf      = req_valid && req_ready;
      rf_addr = req_addr;
      ifire   = inst_valid && inst_ready;
      if (ifire) begin
         word = mem_word(exp_pc);
         checkOutput("inst_pc", inst_pc, exp_pc);
         checkOutput("inst", inst, word);
         hit_ebreak = (word == INST_EBREAK);
         hit_ecall  = (word == INST_ECALL);
         exp_pc = exp_pc + 32'd4;
         delivered++;
         last_deliver = cycle;
      end
      if (rf) begin
         checkOutput("req_addr", rf_addr, exp_fetch);
         exp_fetch = exp_fetch + 32'd4;
         req_count++;
      end
      if (redir && !halt_model) begin
         exp_pc    = {target[31:2], 2'b00};
         exp_fetch = exp_pc;
      end
      @(posedge clk);
      cycle++;
      if (resp_valid) begin
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end
      if (rf) begin
         pend_addr.push_back(rf_addr);
         pend_due.push_back(cycle + int'($urandom_range(lat_max, lat_min)) - 1);
      end
      #1;
      if (hit_ebreak) begin
         halt_model = 1'b1;
         checkOutput("ebreak_pulse", ebreak_o, 1);
         checkOutput("ebreak_halted", halted, 1);
         checkOutput("ebreak_req_valid", req_valid, 0);
         checkOutput("ebreak_inst_valid", inst_valid, 0);
      end else if (hit_ecall) begin
         checkOutput("ecall_no_pulse", ebreak_o, 0);
         checkOutput("ecall_no_halt", halted, 0);
      end else if (halt_model) begin
         checkOutput("halt_req_valid", req_valid, 0);
         checkOutput("halt_inst_valid", inst_valid, 0);
         checkOutput("halt_flag", halted, 1);
         checkOutput("halt_pulse_once", ebreak_o, 0);
      end
   endtask

   initial begin
      b_rst = 1'b1; b_req_ready = 1'b1; b_resp_valid = 1'b0; b_resp_data = '0;
      b_inst_ready = 1'b0; b_redirect_valid = 1'b0; b_redirect_pc = '0;
      ebreak_addr = 32'h1; ecall_addr = 32'h1;
      lat_min = 1; lat_max = 1; ready_pct = 100; inst_pct = 100;

      // Decode stalled: only DEPTH fetches may be in flight or buffered.
      doReset();
      inst_pct = 0;
      repeat (8) applyStimulus(1'b0, '0);
      checkOutput("credit_req_count", req_count, DEPTH);
      checkOutput("credit_req_valid", req_valid, 0);
      checkOutput("credit_inst_valid", inst_valid, 1);
      checkOutput("credit_inst_pc", inst_pc, RESET_PC);

      // Release decode, 1-cycle memory: sequential stream resumes at 8000_0008.
      inst_pct = 100;
      d0 = delivered;
      repeat (20) applyStimulus(1'b0, '0);
      checkOutput("stream_progress", (delivered - d0 >= 10), 1);

      // Redirect while fetches are in flight on a slow memory.
      lat_min = 3; lat_max = 3;
      repeat (6) applyStimulus(1'b0, '0);
      applyStimulus(1'b1, 32'h8000_0100);
      repeat (14) applyStimulus(1'b0, '0);
      checkOutput("redirect_progress", (exp_pc > 32'h8000_0100), 1);

      // Random handshakes, latencies and redirects (unaligned targets included).
      lat_min = 1; lat_max = 3; ready_pct = 70; inst_pct = 60;
      d0 = delivered;
      for (int i = 0; i < 600; i++) begin
         if (int'($urandom_range(99)) < 8)
            applyStimulus(1'b1, 32'h8000_0000 + 32'($urandom_range(32'hFFF)));
         else
            applyStimulus(1'b0, '0);
         if (cycle - last_deliver > 60) break;
      end
      checkOutput("random_liveness", (cycle - last_deliver <= 60), 1);
      checkOutput("random_progress", (delivered - d0 > 100), 1);

      // Reset in the middle of traffic restarts at RESET_PC.
      doReset();
      ready_pct = 100; inst_pct = 100;
      d0 = delivered;
      repeat (12) applyStimulus(1'b0, '0);
      checkOutput("after_reset_progress", (delivered - d0 >= 4), 1);

      // ecall at +4 must not halt; ebreak at +8 halts and ignores redirects.
      doReset();
      ecall_addr = 32'h8000_0004; ebreak_addr = 32'h8000_0008;
      lat_min = 1; lat_max = 2;
      for (int i = 0; i < 40 && !halt_model; i++) applyStimulus(1'b0, '0);
      checkOutput("ebreak_reached", halt_model, 1);
      for (int i = 0; i < 10; i++) applyStimulus((i % 3) == 0, 32'h8000_0200);
      ecall_addr = 32'h1; ebreak_addr = 32'h1;

      // PC increment wraps modulo 2^32.
      @(posedge clk); #1;
      b_rst = 1'b0; #1;
      checkOutput("wrap_first_valid", b_req_valid, 1);
      checkOutput("wrap_first_addr", b_req_addr, WRAP_PC);
      checkOutput("wrap_inst_valid", b_inst_valid, 0);
      @(posedge clk); #1;
      checkOutput("wrap_next_addr", b_req_addr, 32'h0000_0000);
      checkOutput("wrap_not_halted", b_halted, 0);
      checkOutput("wrap_no_ebreak", b_ebreak_o, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
